// File: rtl/present_req_sched.sv
// present_req_sched: round-robin scheduler that shares one iterative PRESENT-80
// core between NREQ requesters. Only one job is in flight at a time. A job is
// granted, then issued to the core with a start pulse. The scheduler waits for
// the core's done pulse and returns the ciphertext tagged with the requester id.
//
// Optional feature: define PRESENT_TIMEOUT_EN to add a watchdog on the core.
// When the core does not answer within TIMEOUT cycles of core_start, the job is
// aborted and answered with rsp_ct=0 and rsp_err=1. Without the macro the
// scheduler waits indefinitely and rsp_err is tied low.
module present_req_sched #(
    parameter int NREQ    = 4,
    parameter int IDW     = $clog2(NREQ),
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [64*NREQ-1:0]   req_pt,
    input  logic [80*NREQ-1:0]   req_key,
    output logic                 core_start,
    output logic [63:0]          core_pt,
    output logic [79:0]          core_key,
    input  logic                 core_done,
    input  logic [63:0]          core_ct,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [63:0]          rsp_ct,
    output logic                 rsp_err
);

    // Reject parameter sets the scheduler was not built for.
    if ((NREQ < 2) || (NREQ > 8) || (IDW != $clog2(NREQ)) || (TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_param_check
        $error("present_req_sched: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [63:0]       core_pt_q, core_pt_d;
    logic [79:0]       core_key_q, core_key_d;
    logic              core_start_q, core_start_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]    rsp_id_q, rsp_id_d;
    logic [63:0]       rsp_ct_q, rsp_ct_d;

    logic              hi_found_s, lo_found_s, grant_found_s;
    logic [IDW-1:0]    hi_idx_s, lo_idx_s, grant_idx_s;
    logic [63:0]       grant_pt_s;
    logic [79:0]       grant_key_s;
    logic [NREQ-1:0]   req_ready_s;
    logic              wdog_abort_s;

    // Round-robin pick: lowest valid index at or above the pointer, else the lowest valid overall (wrap).
    always_comb begin
        hi_found_s = 1'b0;
        lo_found_s = 1'b0;
        hi_idx_s   = {IDW{1'b0}};
        lo_idx_s   = {IDW{1'b0}};
        for (int i = NREQ - 1; i >= 0; i--) begin
            lo_found_s = req_valid[i] ? 1'b1     : lo_found_s;
            lo_idx_s   = req_valid[i] ? IDW'(i)  : lo_idx_s;
            hi_found_s = (req_valid[i] && (IDW'(i) >= ptr_q)) ? 1'b1    : hi_found_s;
            hi_idx_s   = (req_valid[i] && (IDW'(i) >= ptr_q)) ? IDW'(i) : hi_idx_s;
        end
        grant_found_s = lo_found_s;
        grant_idx_s   = hi_found_s ? hi_idx_s : lo_idx_s;
    end

    // AND-OR mux selecting the granted requester's plaintext and key.
    always_comb begin
        grant_pt_s  = 64'd0;
        grant_key_s = 80'd0;
        for (int i = 0; i < NREQ; i++) begin
            grant_pt_s  = grant_pt_s  | (req_pt[64*i +: 64]  & {64{IDW'(i) == grant_idx_s}});
            grant_key_s = grant_key_s | (req_key[80*i +: 80] & {80{IDW'(i) == grant_idx_s}});
        end
    end

`ifdef PRESENT_TIMEOUT_EN
    localparam logic [7:0] WDOG_LIM = 8'(TIMEOUT);

    logic [7:0] wdog_q, wdog_d;
    logic       rsp_err_q, rsp_err_d;

    // Watchdog: cleared while issuing, counts every cycle spent waiting on the core.
    always_comb begin
        wdog_d = wdog_q;
        case (state_q)
            ST_ISSUE: wdog_d = 8'd0;
            ST_WAIT:  wdog_d = wdog_q + 8'd1;
            default:  wdog_d = wdog_q;
        endcase
    end

    // A real done in the last allowed cycle wins over the abort.
    assign wdog_abort_s = (state_q == ST_WAIT) && !core_done && ((wdog_q + 8'd1) == WDOG_LIM);

    // Error flag is raised only alongside an aborted response and cleared once it is accepted.
    always_comb begin
        rsp_err_d = rsp_err_q;
        case (state_q)
            ST_WAIT: begin
                if (core_done) begin
                    rsp_err_d = 1'b0;
                end else if (wdog_abort_s) begin
                    rsp_err_d = 1'b1;
                end else begin
                    rsp_err_d = rsp_err_q;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_err_d = 1'b0;
                end else begin
                    rsp_err_d = rsp_err_q;
                end
            end
            default: rsp_err_d = 1'b0;
        endcase
    end

    // Watchdog and error flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q    <= 8'd0;
            rsp_err_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign wdog_abort_s = 1'b0;
    assign rsp_err      = 1'b0;
`endif

    // Scheduler next-state: grant in IDLE, one-cycle issue, wait for the core, hold the response until taken.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        core_pt_d   = core_pt_q;
        core_key_d  = core_key_q;
        rsp_id_d    = rsp_id_q;
        rsp_ct_d    = rsp_ct_q;
        req_ready_s = {NREQ{1'b0}};
        case (state_q)
            ST_IDLE: begin
                if (grant_found_s) begin
                    state_d    = ST_ISSUE;
                    ptr_d      = (grant_idx_s == IDW'(NREQ - 1)) ? {IDW{1'b0}} : (grant_idx_s + IDW'(1));
                    core_pt_d  = grant_pt_s;
                    core_key_d = grant_key_s;
                    rsp_id_d   = grant_idx_s;
                    for (int i = 0; i < NREQ; i++) begin
                        req_ready_s[i] = (IDW'(i) == grant_idx_s);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_done) begin
                    rsp_ct_d = core_ct;
                    state_d  = ST_RESP;
                end else if (wdog_abort_s) begin
                    rsp_ct_d = 64'd0;
                    state_d  = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        core_start_d = (state_d == ST_ISSUE);
        rsp_valid_d  = (state_d == ST_RESP);
    end

    // State, job latches and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ptr_q        <= {IDW{1'b0}};
            core_pt_q    <= 64'd0;
            core_key_q   <= 80'd0;
            core_start_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= {IDW{1'b0}};
            rsp_ct_q     <= 64'd0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            core_pt_q    <= core_pt_d;
            core_key_q   <= core_key_d;
            core_start_q <= core_start_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_ct_q     <= rsp_ct_d;
        end
    end

    // The accept is combinational so the handshake completes in the grant cycle; held low in reset.
    assign req_ready  = req_ready_s & {NREQ{rst_n}};
    assign core_start = core_start_q;
    assign core_pt    = core_pt_q;
    assign core_key   = core_key_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_ct     = rsp_ct_q;

endmodule

// File: tb/tb_present_req_sched.sv
// Bench for present_req_sched: random requesters, a behavioural PRESENT-80 core
// with random latency, and a negedge monitor that checks grants, core issue and
// responses against a round-robin reference model and a response scoreboard.
module tb_present_req_sched;

    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 64;

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [64*NREQ-1:0]  req_pt;
    logic [80*NREQ-1:0]  req_key;
    logic                core_start;
    logic [63:0]         core_pt;
    logic [79:0]         core_key;
    logic                core_done;
    logic [63:0]         core_ct;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [63:0]         rsp_ct;
    logic                rsp_err;

    present_req_sched #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_pt(req_pt), .req_key(req_key),
        .core_start(core_start), .core_pt(core_pt), .core_key(core_key),
        .core_done(core_done), .core_ct(core_ct),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_ct(rsp_ct),
        .rsp_err(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [63:0]    ct;
        logic           err;
    } exp_t;

    exp_t sb[$];
    int   grant_log[$];
    int   vectors = 0;
    int   miscompares = 0;

    // reference model of the scheduler's job lifecycle
    int          m_ptr = 0;
    bit          m_busy = 1'b0, m_issue = 1'b0, m_wait = 1'b0, m_resp = 1'b0;
    int          m_wcnt = 0;
    logic [63:0] m_pt = 64'd0;
    logic [79:0] m_key = 80'd0;

    // core model controls
    bit          core_suppress = 1'b0;
    int          core_lat_min = 1;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [63:0] tbl;
        tbl = 64'h2174_8FE3_DA09_B65C;
        return tbl[4*x +: 4];
    endfunction

    function automatic logic [63:0] present80(input logic [63:0] pt, input logic [79:0] key);
        logic [63:0] s;
        logic [63:0] p;
        logic [79:0] k;
        s = pt;
        k = key;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ k[79:16];
            for (int n = 0; n < 16; n++) s[4*n +: 4] = sbox(s[4*n +: 4]);
            p = 64'd0;
            for (int b = 0; b < 63; b++) p[(b * 16) % 63] = s[b];
            p[63] = s[63];
            s = p;
            k = {k[18:0], k[79:19]};
            k[79:76] = sbox(k[79:76]);
            k[19:15] = k[19:15] ^ 5'(r);
        end
        return s ^ k[79:16];
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural core: random latency, real PRESENT-80 ----------------
    int          core_cnt = 0;
    logic [63:0] core_ct_pend = 64'd0;
    initial begin
        core_done = 1'b0;
        core_ct   = 64'd0;
        forever begin
            @(posedge clk);
            #1;
            core_done = 1'b0;
            core_ct   = {$urandom(), $urandom()};
            if (core_cnt > 0) begin
                core_cnt--;
                if (core_cnt == 0) begin
                    core_done = 1'b1;
                    core_ct   = core_ct_pend;
                end
            end
            if (core_start) begin
                core_ct_pend = present80(core_pt, core_key);
                core_cnt     = core_suppress ? 0 : $urandom_range(40, core_lat_min);
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            logic [NREQ-1:0] exp_rdy;
            bit   gnt;
            bit   nxt_resp;
            int   g;
            exp_t e;
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_req_ready", req_ready, 0);
                chk("rst_core_start", core_start, 0);
                chk("rst_rsp_valid", rsp_valid, 0);
                chk("rst_rsp_err", rsp_err, 0);
                chk("rst_rsp_id", rsp_id, 0);
                chk("rst_rsp_ct", rsp_ct, 0);
                chk("rst_core_pt", core_pt, 0);
                chk("rst_core_key", core_key, 0);
                m_ptr = 0; m_busy = 0; m_issue = 0; m_wait = 0; m_resp = 0; m_wcnt = 0;
                sb.delete();
                grant_log.delete();
            end else begin
                gnt = 1'b0;
                g = 0;
                exp_rdy = '0;
                if (!m_busy && (req_valid != '0)) begin
                    for (int k = 0; k < NREQ; k++) begin
                        int c;
                        c = (m_ptr + k) % NREQ;
                        if (!gnt && req_valid[c]) begin
                            gnt = 1'b1;
                            g = c;
                        end
                    end
                    exp_rdy[g] = 1'b1;
                end
                chk("req_ready", req_ready, exp_rdy);
                chk("core_start", core_start, m_issue);
                if (m_issue) begin
                    chk("core_pt", core_pt, m_pt);
                    chk("core_key", core_key, m_key);
                end
                chk("rsp_valid", rsp_valid, m_resp);
                if (m_resp && rsp_valid) begin
                    if (sb.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL rsp_unexpected: got id %0d ct %0h with no job pending", rsp_id, rsp_ct);
                    end else begin
                        chk("rsp_id", rsp_id, sb[0].id);
                        chk("rsp_ct", rsp_ct, sb[0].ct);
                        chk("rsp_err", rsp_err, sb[0].err);
                    end
                end
                nxt_resp = m_resp;
                if (m_resp && rsp_ready) begin
                    if (sb.size() > 0) void'(sb.pop_front());
                    nxt_resp = 1'b0;
                    m_busy = 1'b0;
                end
                if (m_wait) begin
                    m_wcnt++;
                    if (core_done) begin
                        m_wait = 1'b0;
                        nxt_resp = 1'b1;
                    end
`ifdef PRESENT_TIMEOUT_EN
                    else if (m_wcnt == TIMEOUT) begin
                        m_wait = 1'b0;
                        nxt_resp = 1'b1;
                        if (sb.size() > 0) begin
                            e = sb[0];
                            e.ct = 64'd0;
                            e.err = 1'b1;
                            sb[0] = e;
                        end
                    end
`endif
                end
                if (m_issue) begin
                    m_wait = 1'b1;
                    m_wcnt = 0;
                end
                m_issue = gnt;
                if (gnt) begin
                    m_busy = 1'b1;
                    m_ptr = (g + 1) % NREQ;
                    m_pt = req_pt[64*g +: 64];
                    m_key = req_key[80*g +: 80];
                    e.id = IDW'(g);
                    e.ct = present80(m_pt, m_key);
                    e.err = 1'b0;
                    sb.push_back(e);
                    grant_log.push_back(g);
                end
                m_resp = nxt_resp;
            end
        end
    end

    // ---------------- stimulus ----------------
    bit              hold[NREQ];
    logic [63:0]     spt[NREQ];
    logic [79:0]     skey[NREQ];
    logic [NREQ-1:0] acc;
    int              stall = 0;

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = hold[i];
            req_pt[64*i +: 64] = spt[i];
            req_key[80*i +: 80] = skey[i];
        end
    endtask

    task automatic new_job(input int i);
        hold[i] = 1'b1;
        spt[i]  = {$urandom(), $urandom()};
        skey[i] = 80'({$urandom(), $urandom(), $urandom()});
    endtask

    task automatic step(input int p_new, input int p_drop, input int p_rdy);
        bit dropped;
        @(negedge clk);
        acc = req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            dropped = 1'b0;
            if (hold[i] && acc[i]) begin
                hold[i] = 1'b0;
            end else if (hold[i] && ($urandom_range(99, 0) < p_drop)) begin
                hold[i] = 1'b0;
                dropped = 1'b1;
            end
            if (!hold[i] && !dropped && ($urandom_range(99, 0) < p_new)) new_job(i);
        end
        if (p_rdy >= 100) begin
            stall = 0;
            rsp_ready = 1'b1;
        end else if (stall > 0) begin
            stall--;
            rsp_ready = 1'b0;
        end else if ($urandom_range(99, 0) < 3) begin
            stall = 10;
            rsp_ready = 1'b0;
        end else begin
            rsp_ready = ($urandom_range(99, 0) < p_rdy);
        end
        drive();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int n;
        for (int i = 0; i < NREQ; i++) hold[i] = 1'b0;
        drive();
        n = 0;
        while ((m_busy || sb.size() != 0) && n < 400) begin
            step(0, 0, 100);
            n++;
        end
        if (m_busy || sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: job still pending after %0d cycles", n);
        end
    endtask

    initial begin
        int n;
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        rst_n = 1'b0;
        rsp_ready = 1'b0;
        req_valid = '0;
        req_pt = '0;
        req_key = '0;
        for (int i = 0; i < NREQ; i++) begin
            hold[i] = 1'b0;
            spt[i] = 64'd0;
            skey[i] = 80'd0;
        end
        chk("present_kat", present80(64'd0, 80'd0), 64'h5579C1387B228445);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // single job from requester 0 with all-zero plaintext and key
        hold[0] = 1'b1;
        spt[0] = 64'd0;
        skey[0] = 80'd0;
        rsp_ready = 1'b1;
        drive();
        n = 0;
        while (grant_log.size() == 0 && n < 20) begin
            step(0, 0, 100);
            n++;
        end
        chk("first_grant_seen", grant_log.size(), 1);
        drain();

        // all requesters held valid straight out of reset: strict round-robin order
        for (int i = 0; i < NREQ; i++) new_job(i);
        drive();
        do_reset();
        n = 0;
        while (grant_log.size() < 5 && n < 500) begin
            step(100, 0, 100);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            if (i < grant_log.size()) chk("grant_order", grant_log[i], exp_order[i]);
            else chk("grant_order_missing", 0, 1);
        end
        drain();

        // random traffic with early withdrawal and response backpressure
        repeat (3000) step(30, 2, 70);
        drain();

        // reset while the core is busy: job dropped, late done must not produce a response
        core_lat_min = 20;
        new_job(1);
        drive();
        n = 0;
        while (!m_wait && n < 20) begin
            step(0, 0, 100);
            n++;
        end
        chk("reset_test_wait_reached", m_wait, 1);
        step(0, 0, 100);
        step(0, 0, 100);
        for (int i = 0; i < NREQ; i++) hold[i] = 1'b0;
        drive();
        do_reset();
        repeat (60) step(0, 0, 100);
        core_lat_min = 1;

`ifdef PRESENT_TIMEOUT_EN
        // core never answers: aborted response with error flag
        core_suppress = 1'b1;
        new_job(2);
        drive();
        repeat (TIMEOUT + 20) step(0, 0, 100);
        core_suppress = 1'b0;
`endif

        drain();
        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
